// File: rtl/sr_latch_driver_if.sv
// rtl/sr_latch_driver_if.sv - request/status bundle between control logic and sr_latch_driver
//
// Signals:
//   set_req  - request to set the latch (Q=1), honoured only while idle
//   clr_req  - request to clear the latch (Q=0), honoured only while idle
//   busy     - driver is executing an operation
//   done     - one-cycle pulse at the end of every accepted operation
//   err      - one-cycle fault pulse (forbidden request or failed readback)
//   q_state  - last target value confirmed by a clean readback
// Modports: master = requesting logic, slave = sr_latch_driver.

interface sr_latch_driver_if;
    logic set_req;
    logic clr_req;
    logic busy;
    logic done;
    logic err;
    logic q_state;

    modport master (
        output set_req,
        output clr_req,
        input  busy,
        input  done,
        input  err,
        input  q_state
    );

    modport slave (
        input  set_req,
        input  clr_req,
        output busy,
        output done,
        output err,
        output q_state
    );
endinterface

// File: rtl/sr_latch_driver.sv
// rtl/sr_latch_driver.sv - clocked S/R pulse generator and readback checker for a NOR SR latch
//
// Turns single-cycle set/clear requests into width-controlled S/R pulses,
// waits for the latch to settle, then checks the synchronized Q/Qbar
// readback against the requested value.
//
// Parameters:
//   PULSE_CYCLES  - cycles S or R is held high (1..255)
//   SETTLE_CYCLES - quiet cycles with S=R=0 before the readback check (2..255)
// Ports:
//   clk      - rising-edge clock
//   rst      - synchronous active-high reset
//   ctl      - request/status bundle (slave side)
//   S, R     - registered latch drives, never high together
//   Q_fb     - latch Q, asynchronous to clk
//   Qbar_fb  - latch Qbar, asynchronous to clk

module sr_latch_driver #(
    parameter int PULSE_CYCLES  = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    sr_latch_driver_if.slave   ctl,
    output logic               S,
    output logic               R,
    input  logic               Q_fb,
    input  logic               Qbar_fb
);

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        SETTLE,
        CHECK
    } state_t;

    // The counter starts at 0 on state entry, so the last cycle of a phase
    // is the one where it equals length-1.
    localparam logic [7:0] PULSE_LAST  = 8'(PULSE_CYCLES - 1);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    state_t     state;
    state_t     state_next;
    logic [7:0] cnt;
    logic [7:0] cnt_next;
    logic       s_q;
    logic       s_next;
    logic       r_q;
    logic       r_next;
    logic       target;
    logic       target_next;
    logic       q_state_q;
    logic       q_state_next;
    logic       forbid_err;
    logic       forbid_next;

    // Two-flop synchronizers for the asynchronous latch outputs.
    logic       qs_meta;
    logic       qs;
    logic       qbs_meta;
    logic       qbs;

    logic       fb_ok;
    logic       set_only;
    logic       clr_only;
    logic       both_req;

    assign set_only = ctl.set_req & ~ctl.clr_req;
    assign clr_only = ctl.clr_req & ~ctl.set_req;
    assign both_req = ctl.set_req & ctl.clr_req;

    // Q and Qbar must both agree with the target; Q=Qbar=0 (latch held by
    // an active input or broken) is a fault just like a stuck value.
    assign fb_ok = (qs == target) && (qbs == ~target);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            target     <= 1'b0;
            q_state_q  <= 1'b0;
            forbid_err <= 1'b0;
            qs_meta    <= 1'b0;
            qs         <= 1'b0;
            qbs_meta   <= 1'b0;
            qbs        <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            s_q        <= s_next;
            r_q        <= r_next;
            target     <= target_next;
            q_state_q  <= q_state_next;
            forbid_err <= forbid_next;
            qs_meta    <= Q_fb;
            qs         <= qs_meta;
            qbs_meta   <= Qbar_fb;
            qbs        <= qbs_meta;
        end
    end

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        s_next       = s_q;
        r_next       = r_q;
        target_next  = target;
        q_state_next = q_state_q;
        forbid_next  = 1'b0;

        case (state)
            IDLE: begin
                cnt_next = 8'd0;
                s_next   = 1'b0;
                r_next   = 1'b0;
                if (set_only) begin
                    target_next = 1'b1;
                    s_next      = 1'b1;
                    state_next  = PULSE;
                end else if (clr_only) begin
                    target_next = 1'b0;
                    r_next      = 1'b1;
                    state_next  = PULSE;
                end else if (both_req) begin
                    // Driving S and R together would leave the NOR latch in
                    // an undefined state on release; refuse and flag it.
                    forbid_next = 1'b1;
                end
            end

            PULSE: begin
                if (cnt == PULSE_LAST) begin
                    s_next     = 1'b0;
                    r_next     = 1'b0;
                    cnt_next   = 8'd0;
                    state_next = SETTLE;
                end else begin
                    cnt_next = cnt + 8'd1;
                end
            end

            SETTLE: begin
                s_next = 1'b0;
                r_next = 1'b0;
                if (cnt == SETTLE_LAST) begin
                    cnt_next   = 8'd0;
                    state_next = CHECK;
                end else begin
                    cnt_next = cnt + 8'd1;
                end
            end

            CHECK: begin
                s_next     = 1'b0;
                r_next     = 1'b0;
                cnt_next   = 8'd0;
                state_next = IDLE;
                if (fb_ok) begin
                    q_state_next = target;
                end
            end

            default: begin
                s_next     = 1'b0;
                r_next     = 1'b0;
                cnt_next   = 8'd0;
                state_next = IDLE;
            end
        endcase
    end

    assign S           = s_q;
    assign R           = r_q;
    assign ctl.busy    = (state != IDLE);
    assign ctl.done    = (state == CHECK);
    assign ctl.err     = forbid_err | ((state == CHECK) & ~fb_ok);
    assign ctl.q_state = q_state_q;

endmodule

// File: doc/sr_latch_driver.md
# sr_latch_driver

Clocked initiator for the NOR-based SR latch used in Lab 6. It turns single-cycle set/clear requests from synchronous logic into clean, width-controlled S/R pulses, and never drives S and R high together. It then reads back the latch's Q/Qbar through a synchronizer and reports completion or fault. It sits between the lab's synchronous control logic and the asynchronous latch, driving the latch's S/R inputs and observing its Q/Qbar outputs.

## Interface
- PULSE_CYCLES, 4, cycles S or R is held high per operation; legal range 1..255
- SETTLE_CYCLES, 2, cycles with S=R=0 after a pulse before feedback is checked; legal range 2..255
- clk  input  1  rising-edge clock
- rst  input  1  reset; synchronous and active-high
- set_req  input  1  request to set the latch (Q=1); sampled only in IDLE
- clr_req  input  1  request to clear the latch (Q=0); sampled only in IDLE
- S  output  1  latch set drive, registered
- R  output  1  latch reset drive, registered
- Q_fb  input  1  latch Q, asynchronous
- Qbar_fb  input  1  latch Qbar, asynchronous
- busy  output  1  high whenever the FSM is not in IDLE
- done  output  1  one-cycle pulse at the end of every accepted operation
- err  output  1  one-cycle fault pulse
- q_state  output  1  last target value confirmed by a fault-free check

## Operation
- Reset, applied on a clk edge with rst=1: state=IDLE, S=0, R=0, busy=0, done=0, err=0, q_state=0, both synchronizer stages=0, counter=0. Reset wins over every other event, including mid-pulse; S and R are 0 from that edge onward. The latch itself is not driven by reset and keeps its value.
- Feedback path: Q_fb and Qbar_fb each pass through a 2-flop synchronizer (qs, qbs). All checks use the synchronized values only.
- FSM states: IDLE, PULSE, SETTLE, CHECK.
- IDLE, set_req=1 and clr_req=0: target=1, S<=1, go to PULSE.
- IDLE, clr_req=1 and set_req=0: target=0, R<=1, go to PULSE.
- IDLE, set_req=1 and clr_req=1: forbidden. No pulse is issued, err=1 for one cycle, state stays IDLE, done stays 0.
- PULSE: counter runs 1..PULSE_CYCLES. On the last count, S<=0, R<=0, and the FSM goes to SETTLE.
- SETTLE: counter runs 1..SETTLE_CYCLES with S=R=0. Then go to CHECK.
- CHECK (exactly one cycle): done=1. If qs==target and qbs==~target, q_state<=target and err=0. Otherwise err=1 and q_state is unchanged. Next state is IDLE.
- Requests arriving while busy=1 are ignored, not queued. This includes the CHECK cycle.
- Invariants: S&R is never 1. S and R are never both high in adjacent cycles across operations, because SETTLE guarantees at least 2 zero cycles between pulses.
- The counter is 8 bits and is cleared on every state entry. It never wraps inside legal parameter ranges.

## Timing
- Request sampled at edge e0 in IDLE.
- S or R is high for cycles e0+1 .. e0+PULSE_CYCLES, i.e. it rises at edge e0 and falls at edge e0+PULSE_CYCLES.
- SETTLE occupies cycles e0+PULSE_CYCLES+1 .. e0+PULSE_CYCLES+SETTLE_CYCLES.
- done and err (check result) are high in cycle e0+PULSE_CYCLES+SETTLE_CYCLES+1. With defaults this is 7 cycles after the accepting edge.
- q_state updates at the edge ending the CHECK cycle.
- busy rises at e0 and falls at the edge after CHECK. The earliest next acceptance is that same edge's following cycle, giving a back-to-back period of PULSE_CYCLES+SETTLE_CYCLES+2 cycles.
- The forbidden-request err pulse occurs in the cycle after the sampling edge.
- The synchronizer latency is 2 cycles. SETTLE_CYCLES>=2 guarantees the feedback reflects the pulse's effect by CHECK.

## Test plan
- Set with defaults: pulse set_req for 1 cycle with latch Q=0. Required: S high for exactly 4 cycles, R=0 throughout, done high 7 cycles after acceptance, err=0, q_state=1.
- Clear after set: pulse clr_req. Required: R high for 4 cycles, S=0, done at +7, q_state=0. Also issue set_req while busy; it must be ignored (S stays 0).
- Forbidden input: set_req=clr_req=1 in IDLE. Required: S=R=0, err=1 for one cycle, done=0, busy=0, q_state unchanged.
- Stuck feedback: force Q_fb=0 and Qbar_fb=1 during a set. Required: done=1 and err=1 in the same cycle, q_state stays 0. A second case forces Q_fb=Qbar_fb=0 and must also produce err=1.
- Reset mid-pulse: assert rst on the 2nd cycle of S high. Required: S=0 from that edge, busy=0, done=0, err=0, q_state=0, and a fresh set_req afterward completes normally at +7.
- Back-to-back with PULSE_CYCLES=1, SETTLE_CYCLES=2: hold set_req high continuously. Required: S pulses 1 cycle wide every 5 cycles, never overlapping R, done every 5 cycles.
